// File: rtl/fp_wire.sv
// fp_wire: shared types for fp_unit and its request front-end fp_issue.
//   fp_operation_type  - one-hot op decode plus fcvt sub-op, as fp_unit expects
//   fp_unit_in_type    - operands, rounding mode, format, op decode, enable
//   fp_unit_out_type   - result, exception flags, ready strobe
//   fp_issue_req_type  - request: three operands, rm, fcvt op, 10-bit one-hot opcode
//   fp_issue_rsp_type  - response: result, flags, tag
package fp_wire;

  typedef struct packed {
    logic       fmadd;
    logic       fmsub;
    logic       fnmadd;
    logic       fnmsub;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fsgnj;
    logic       fcmp;
    logic       fmax;
    logic       fclass;
    logic       fmv_i2f;
    logic       fmv_f2i;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    fp_operation_type op;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic             enable;
  } fp_unit_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_unit_out_type;

  // Request opcode bit positions; bit 7 is reserved and always illegal.
  localparam int OPC_W        = 10;
  localparam int OPC_FMADD    = 0;
  localparam int OPC_FADD     = 1;
  localparam int OPC_FSUB     = 2;
  localparam int OPC_FMUL     = 3;
  localparam int OPC_FDIV     = 4;
  localparam int OPC_FSQRT    = 5;
  localparam int OPC_FCMP     = 6;
  localparam int OPC_RSVD     = 7;
  localparam int OPC_FCVT_I2F = 8;
  localparam int OPC_FCVT_F2I = 9;

  // Response tags are carried at this fixed width; fp_issue zero-extends its
  // TAGW-bit tag into it, so TAGW must not exceed this.
  localparam int FP_ISSUE_TAGW_MAX = 8;

  localparam logic [4:0] FLAGS_ILLEGAL = 5'b10000;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    logic [2:0]       rm;
    logic [1:0]       op;
    logic [OPC_W-1:0] opcode;
  } fp_issue_req_type;

  typedef struct packed {
    logic [31:0]                  result;
    logic [4:0]                   flags;
    logic [FP_ISSUE_TAGW_MAX-1:0] tag;
  } fp_issue_rsp_type;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } fp_issue_state_type;

  // Exactly one defined opcode bit set.
  function automatic logic opcode_legal(input logic [OPC_W-1:0] opcode);
    return $onehot(opcode) && !opcode[OPC_RSVD];
  endfunction

  // Map a (legal) request opcode onto fp_unit's op decode; ops the front-end
  // never issues stay 0.
  function automatic fp_operation_type decode_op(input logic [OPC_W-1:0] opcode,
                                                 input logic [1:0]       fcvt_op);
    fp_operation_type d;
    d          = '0;
    d.fmadd    = opcode[OPC_FMADD];
    d.fadd     = opcode[OPC_FADD];
    d.fsub     = opcode[OPC_FSUB];
    d.fmul     = opcode[OPC_FMUL];
    d.fdiv     = opcode[OPC_FDIV];
    d.fsqrt    = opcode[OPC_FSQRT];
    d.fcmp     = opcode[OPC_FCMP];
    d.fcvt_i2f = opcode[OPC_FCVT_I2F];
    d.fcvt_f2i = opcode[OPC_FCVT_F2I];
    d.fcvt_op  = fcvt_op;
    return d;
  endfunction

endpackage

// File: rtl/fp_issue_fifo.sv
// fp_issue_fifo: synchronous FIFO of DEPTH entries, W bits wide.
//   clock, reset (async, active-low)
//   push, wdata  - write when push && !full
//   pop, rdata   - rdata shows the head; pop removes it when !empty
//   full, empty  - derived from (log2(DEPTH)+1)-bit pointers
module fp_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  // Pointers carry one extra MSB: equal low bits with differing MSBs is full.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop  && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fp_issue.sv
// fp_issue: request front-end for fp_unit.
//   clock, reset (async, active-low)
//   req_valid/req_ready/req  - request channel, buffered in a DEPTH-entry FIFO
//   fp_unit_i                - registered operands/op decode, one-cycle enable
//   fp_unit_o                - result/flags/ready from fp_unit
//   rsp_valid/rsp_ready/rsp  - single-entry tagged response slot
//   err                      - sticky: fp_unit ready seen while not busy
// TAGW must not exceed fp_wire::FP_ISSUE_TAGW_MAX.
module fp_issue
  import fp_wire::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  fp_issue_req_type req,
  output fp_unit_in_type   fp_unit_i,
  input  fp_unit_out_type  fp_unit_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output fp_issue_rsp_type rsp,
  output logic             err
);

  typedef struct packed {
    fp_issue_req_type req;
    logic [TAGW-1:0]  tag;
  } entry_t;

  fp_issue_state_type state_q, state_d;
  entry_t             wr_entry, head;
  logic               push, pop, full, empty;
  logic               issue, ld_illegal, ld_done, slot_free;
  logic [TAGW-1:0]    tag_cnt, tag_q;
  fp_unit_in_type     exe_q, exe_d;
  fp_issue_rsp_type   ill_rsp, done_rsp;
  logic [FP_ISSUE_TAGW_MAX-1:0] head_tag_w, busy_tag_w;

  assign req_ready      = !full;
  assign push           = req_valid && !full;
  assign wr_entry.req   = req;
  assign wr_entry.tag   = tag_cnt;
  assign slot_free      = !rsp_valid || rsp_ready;
  assign fp_unit_i      = exe_q;

  fp_issue_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    issue      = 1'b0;
    ld_illegal = 1'b0;
    ld_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Only dequeue when a result would have somewhere to go.
        if (!empty && slot_free) begin
          pop = 1'b1;
          if (opcode_legal(head.req.opcode)) begin
            issue   = 1'b1;
            state_d = S_BUSY;
          end else begin
            ld_illegal = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (fp_unit_o.ready) begin
          ld_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    exe_d        = '0;
    exe_d.data1  = head.req.data1;
    exe_d.data2  = head.req.data2;
    exe_d.data3  = head.req.data3;
    exe_d.rm     = head.req.rm;
    exe_d.op     = decode_op(head.req.opcode, head.req.op);
    exe_d.enable = 1'b1;

    head_tag_w             = '0;
    head_tag_w[TAGW-1:0]   = head.tag;
    busy_tag_w             = '0;
    busy_tag_w[TAGW-1:0]   = tag_q;

    ill_rsp.result  = '0;
    ill_rsp.flags   = FLAGS_ILLEGAL;
    ill_rsp.tag     = head_tag_w;
    done_rsp.result = fp_unit_o.result;
    done_rsp.flags  = fp_unit_o.flags;
    done_rsp.tag    = busy_tag_w;
  end

  // Issue stage: fp_unit inputs are held stable while busy; enable is a pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      exe_q   <= '0;
      tag_q   <= '0;
      tag_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      exe_q.enable <= 1'b0;
      if (issue) begin
        exe_q <= exe_d;
        tag_q <= head.tag;
      end
      if (push) tag_cnt <= tag_cnt + 1'b1;
      if (state_q == S_IDLE && fp_unit_o.ready) err <= 1'b1;
    end
  end

  // Response stage: a load in the same cycle as a drain keeps rsp_valid high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp       <= '0;
    end else if (ld_illegal) begin
      rsp_valid <= 1'b1;
      rsp       <= ill_rsp;
    end else if (ld_done) begin
      rsp_valid <= 1'b1;
      rsp       <= done_rsp;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_issue.sv
module tb_fp_issue;
  import fp_wire::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  fp_issue_req_type req;
  fp_unit_in_type   fp_unit_i;
  fp_unit_out_type  fp_unit_o;
  logic             rsp_valid;
  logic             rsp_ready;
  fp_issue_rsp_type rsp;
  logic             err;

  int checks = 0;
  int errors = 0;

  fp_issue #(.DEPTH(4), .TAGW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req       (req),
    .fp_unit_i (fp_unit_i),
    .fp_unit_o (fp_unit_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp       (rsp),
    .err       (err)
  );

  always #5 clock = ~clock;

  // fp_unit stand-in: ready after lat cycles; 1.0+2.0 gives 3.0, otherwise
  // the result is data1^data2 and flags are data3[4:0].
  int          lat = 1;
  logic        stray = 1'b0;
  logic        m_ready, m_busy;
  logic [31:0] m_result;
  logic [4:0]  m_flags;
  int          m_cnt;
  int          en_cnt = 0;

  assign fp_unit_o.result = m_result;
  assign fp_unit_o.flags  = m_flags;
  assign fp_unit_o.ready  = m_ready | stray;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ready  <= 1'b0;
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      m_result <= '0;
      m_flags  <= '0;
    end else begin
      m_ready <= 1'b0;
      if (fp_unit_i.enable) begin
        en_cnt <= en_cnt + 1;
        if (fp_unit_i.op.fadd && fp_unit_i.data1 == 32'h3F800000 && fp_unit_i.data2 == 32'h40000000)
          m_result <= 32'h40400000;
        else
          m_result <= fp_unit_i.data1 ^ fp_unit_i.data2;
        m_flags <= fp_unit_i.data3[4:0];
        if (lat <= 1) m_ready <= 1'b1;
        else begin
          m_busy <= 1'b1;
          m_cnt  <= lat - 1;
        end
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          m_ready <= 1'b1;
          m_busy  <= 1'b0;
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  // Stream stimulus: request i carries data1=i, data2=0x100, opcode fadd.
  int          n_total, sent, got_n;
  logic [7:0]  got_tag [32];
  logic [31:0] got_res [32];

  task automatic set_req(input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] d3, input logic [9:0] opc);
    req        = '0;
    req.data1  = d1;
    req.data2  = d2;
    req.data3  = d3;
    req.opcode = opc;
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc && got_n < n_total; c++) begin
      logic acc;
      req_valid = (sent < n_total);
      if (req_valid) set_req(sent, 32'h100, 32'h0, 10'h002);
      acc = req_valid && req_ready;
      if (rsp_valid && rsp_ready) begin
        got_tag[got_n] = rsp.tag;
        got_res[got_n] = rsp.result;
        got_n++;
      end
      @(negedge clock);
      if (acc) sent++;
    end
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; stray = 1'b0; lat = 1;
    req = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req = '0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp !== '0) begin errors++; $display("FAIL reset_rsp: got %h want 0", rsp); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (fp_unit_i !== '0) begin errors++; $display("FAIL reset_fp_unit_i: got %h want 0", fp_unit_i); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_fadd();
    do_reset();
    // cycle T
    set_req(32'h3F800000, 32'h40000000, 32'h0, 10'h002);
    req_valid = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fadd_accept: got %b want 1", req_ready); end
    @(negedge clock); // T+1
    req_valid = 1'b0;
    checks++; if (fp_unit_i.enable !== 1'b0) begin errors++; $display("FAIL fadd_en_t1: got %b want 0", fp_unit_i.enable); end
    @(negedge clock); // T+2
    checks++; if (fp_unit_i.enable !== 1'b1 || fp_unit_i.op.fadd !== 1'b1) begin errors++; $display("FAIL fadd_en_t2: got en=%b fadd=%b want 1 1", fp_unit_i.enable, fp_unit_i.op.fadd); end
    checks++; if (fp_unit_i.data1 !== 32'h3F800000 || fp_unit_i.data2 !== 32'h40000000) begin errors++; $display("FAIL fadd_operands: got %h %h want 3f800000 40000000", fp_unit_i.data1, fp_unit_i.data2); end
    @(negedge clock); // T+3: fp_unit ready
    checks++; if (fp_unit_i.enable !== 1'b0 || fp_unit_i.data1 !== 32'h3F800000) begin errors++; $display("FAIL fadd_hold: got en=%b d1=%h want 0 3f800000", fp_unit_i.enable, fp_unit_i.data1); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fadd_rsp_early: got %b want 0", rsp_valid); end
    @(negedge clock); // T+4
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL fadd_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp.result !== 32'h40400000 || rsp.flags !== 5'h0 || rsp.tag !== 8'd0) begin errors++; $display("FAIL fadd_rsp: got %h/%b/%0d want 40400000/00000/0", rsp.result, rsp.flags, rsp.tag); end
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fadd_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_illegal();
    logic saw_en;
    do_reset();
    saw_en = 1'b0;
    set_req(32'h1, 32'h2, 32'h0, 10'h006);
    req_valid = 1'b1;
    @(negedge clock); // T+1
    req_valid = 1'b0;
    saw_en |= fp_unit_i.enable;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ill_rsp_early: got %b want 0", rsp_valid); end
    @(negedge clock); // T+2
    saw_en |= fp_unit_i.enable;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ill_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp.result !== 32'h0 || rsp.flags !== 5'b10000 || rsp.tag !== 8'd0) begin errors++; $display("FAIL ill_rsp: got %h/%b/%0d want 0/10000/0", rsp.result, rsp.flags, rsp.tag); end
    rsp_ready = 1'b1;
    @(negedge clock);
    saw_en |= fp_unit_i.enable;
    checks++; if (saw_en !== 1'b0) begin errors++; $display("FAIL ill_no_enable: got %b want 0", saw_en); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ill_drain: got %b want 0", rsp_valid); end
    set_req(32'h5, 32'h3, 32'h0, 10'h008);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !rsp_valid; c++) @(negedge clock);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ill_next_timeout: got %b want 1", rsp_valid); end
    checks++; if (rsp.result !== 32'h6 || rsp.tag !== 8'd1) begin errors++; $display("FAIL ill_next_rsp: got %h/%0d want 6/1", rsp.result, rsp.tag); end
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    int base;
    do_reset();
    base = en_cnt;
    n_total = 6; sent = 0; got_n = 0;
    rsp_ready = 1'b0;
    run(5);
    checks++; if (sent !== 5) begin errors++; $display("FAIL bp_accepts: got %0d want 5", sent); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", req_ready); end
    run(10);
    checks++; if (sent !== 5 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: got sent=%0d rdy=%b want 5 0", sent, req_ready); end
    checks++; if (en_cnt - base !== 1) begin errors++; $display("FAIL bp_enables: got %0d want 1", en_cnt - base); end
    checks++; if (rsp_valid !== 1'b1 || rsp.tag !== 8'd0) begin errors++; $display("FAIL bp_held: got v=%b tag=%0d want 1 0", rsp_valid, rsp.tag); end
    rsp_ready = 1'b1;
    run(200);
    checks++; if (got_n !== 6) begin errors++; $display("FAIL bp_count: got %0d want 6", got_n); end
    for (int i = 0; i < 6 && i < got_n; i++) begin
      checks++;
      if (got_tag[i] !== 8'(i) || got_res[i] !== (32'(i) ^ 32'h100)) begin
        errors++; $display("FAIL bp_order[%0d]: got tag=%0d res=%h want %0d %h", i, got_tag[i], got_res[i], i, 32'(i) ^ 32'h100);
      end
    end
    checks++; if (en_cnt - base !== 6) begin errors++; $display("FAIL bp_total_enables: got %0d want 6", en_cnt - base); end
  endtask

  task automatic test_tag_wrap();
    do_reset();
    n_total = 17; sent = 0; got_n = 0;
    rsp_ready = 1'b1;
    run(400);
    checks++; if (got_n !== 17) begin errors++; $display("FAIL wrap_count: got %0d want 17", got_n); end
    for (int i = 0; i < 17 && i < got_n; i++) begin
      checks++;
      if (got_tag[i] !== 8'(i % 16)) begin errors++; $display("FAIL wrap_tag[%0d]: got %0d want %0d", i, got_tag[i], i % 16); end
    end
  endtask

  task automatic test_reset_busy();
    logic saw_rsp;
    do_reset();
    lat = 30;
    rsp_ready = 1'b1;
    set_req(32'h40800000, 32'h40000000, 32'h0, 10'h010);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    checks++; if (fp_unit_i.enable !== 1'b1 || fp_unit_i.op.fdiv !== 1'b1) begin errors++; $display("FAIL rb_issue: got en=%b fdiv=%b want 1 1", fp_unit_i.enable, fp_unit_i.op.fdiv); end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (fp_unit_i !== '0) begin errors++; $display("FAIL rb_fp_unit_i: got %h want 0", fp_unit_i); end
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp !== '0 || err !== 1'b0) begin errors++; $display("FAIL rb_outputs: got rdy=%b v=%b rsp=%h err=%b want 1 0 0 0", req_ready, rsp_valid, rsp, err); end
    @(negedge clock);
    reset = 1'b1;
    saw_rsp = 1'b0;
    repeat (40) begin
      @(negedge clock);
      saw_rsp |= rsp_valid;
    end
    checks++; if (saw_rsp !== 1'b0) begin errors++; $display("FAIL rb_no_rsp: got %b want 0", saw_rsp); end
    checks++; if (req_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rb_after: got rdy=%b err=%b want 1 0", req_ready, err); end
    lat = 1;
  endtask

  task automatic test_stray_ready();
    logic saw_rsp;
    do_reset();
    rsp_ready = 1'b1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stray_pre: got %b want 0", err); end
    stray = 1'b1;
    @(negedge clock);
    stray = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stray_err: got %b want 1", err); end
    saw_rsp = rsp_valid;
    repeat (5) begin
      @(negedge clock);
      saw_rsp |= rsp_valid;
    end
    checks++; if (saw_rsp !== 1'b0) begin errors++; $display("FAIL stray_no_rsp: got %b want 0", saw_rsp); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_single_fadd();
    test_illegal();
    test_backpressure();
    test_tag_wrap();
    test_reset_busy();
    test_stray_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
